tx_internal_rx: RTL and testbench
=================================

# tx_internal_rx

Receiving end of the internal TX stream: consumes the unthrottled beat stream (data_en/data/sop/eop/port_id) produced by the TX datapath. It checks framing, repairs or discards malformed or overflowing packets, and buffers words in a show-ahead FIFO. Words are presented downstream on a valid/ready interface where every emitted packet is well-formed (exactly one sop … one eop). It sits between the TX internal stream and any backpressuring consumer (port scheduler, monitor, MAC shim).

## Interface
- TX_DATA_W, global from parameter.sv, data width
- PORT_ID_W, global from parameter.sv, port id width
- FIFO_DEPTH, 16, output FIFO words; power of two, ≥4
- CNT_W, 32, statistics counter width
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_data_en  in  1  input beat valid; no backpressure
- i_data  in  TX_DATA_W  input data
- i_sop  in  1  first beat of packet
- i_eop  in  1  last beat of packet
- i_port_id  in  PORT_ID_W  destination port, sampled per beat
- o_vld  out  1  output word valid
- i_rdy  in  1  downstream ready; transfer when o_vld & i_rdy
- o_data  out  TX_DATA_W  output data
- o_sop / o_eop  out  1 each  output framing
- o_err  out  1  valid on o_eop word: packet truncated/repaired
- o_port_id  out  PORT_ID_W  output port id
- o_pkt_cnt / o_drop_cnt / o_err_cnt  out  CNT_W each  statistics

## Operation
- One-word stage register S between input and FIFO. S holds a word until the next input beat arrives, or, if S.eop, is flushed on the next cycle.
- At most one FIFO write per cycle. A new beat arriving while S is full writes S and loads the new beat in the same cycle.
- free = FIFO_DEPTH − registered occupancy. A same-cycle read is not credited.
- FSM (input framing), reset to IDLE:
  - IDLE: sop → load S, go PKT (stay IDLE if eop also set). Non-sop beat → discard, err_cnt+1.
  - PKT: non-sop beat → normal; eop → IDLE. sop beat → framing error: S is written with eop=1, err=1, err_cnt+1, and the new beat is processed as an IDLE sop.
  - DROP: discard beats; eop → IDLE; sop → treat as IDLE sop.
- Overflow on a required S write:
  - free ≥ 2, or written word carries eop: normal write.
  - free = 1 and word not eop: write with eop=1, err=1, err_cnt+1. Discard the incoming beat; go DROP (IDLE if that beat had eop).
  - free = 0 and S.sop: discard S and the incoming beat; drop_cnt+1; go DROP/IDLE as above. Nothing of that packet is emitted.
  - free = 0 and S.eop pending: S keeps waiting. An incoming sop packet is discarded (drop_cnt+1, DROP).
- A pending S.eop with free = 0 stalls until space is available.
- pkt_cnt increments on each eop word written to the FIFO.
- FIFO is show-ahead: o_vld = !empty, outputs are the head word.

## Timing
- Reset (async assert, sync deassert at use site) clears:
  - FIFO, S and FSM (IDLE)
  - o_vld=0, o_data=0, o_sop=0, o_eop=0, o_err=0, o_port_id=0
  - all counters = 0
- Latency:
  - eop beat at cycle N, FIFO empty → o_vld at N+2.
  - Non-eop beat is written when the next beat arrives, and is visible 1 cycle after that.
- Full throughput: 1 beat/cycle in; 1 word/cycle out when i_rdy is held high.
- o_* must stay stable while o_vld & !i_rdy.
- Counters wrap modulo 2^CNT_W.

## Configuration
- TX_INTERNAL_RX_STAT_EN defined: o_pkt_cnt, o_drop_cnt, o_err_cnt are implemented as above.
- TX_INTERNAL_RX_STAT_EN undefined: counter registers are removed and outputs are tied 0. Datapath, repair and drop behaviour are unchanged.

## Test plan
- Single-beat packet (sop=eop=1, data=0xA5, port 3) at cycle 0, i_rdy=1 → o_vld at cycle 2: data 0xA5, sop=eop=1, err=0, port 3; pkt_cnt=1.
- 4-beat packet followed by a sop at beat 3 (no eop) → first packet emitted as 3 words, last with eop=1, err=1. Second packet intact. err_cnt=1, pkt_cnt=2.
- Non-sop beat in IDLE → nothing emitted, err_cnt=1, FSM stays IDLE.
- FIFO_DEPTH=4, i_rdy=0, 10-beat packet → 4 words stored, 4th has eop=1, err=1. Remaining beats discarded, err_cnt=1, pkt_cnt=1.
- FIFO full with i_rdy=0, then a new 3-beat packet → no words of it emitted, drop_cnt=1. After i_rdy=1, the next packet passes cleanly.
- Reset asserted mid-packet with FIFO holding 3 words → o_vld=0 and counters 0 immediately. The next sop packet is received normally.

Source files
------------

// File: rtl/tx_internal_rx_if.sv
// Downstream valid/ready word stream leaving tx_internal_rx.
// master drives words and framing; slave returns ready.
interface tx_internal_rx_if #(
  parameter int TX_DATA_W = 32,
  parameter int PORT_ID_W = 4
);
  logic                 vld;
  logic                 rdy;
  logic [TX_DATA_W-1:0] data;
  logic                 sop;
  logic                 eop;
  logic                 err;
  logic [PORT_ID_W-1:0] port_id;

  modport master (output vld, data, sop, eop, err, port_id, input rdy);
  modport slave  (input vld, data, sop, eop, err, port_id, output rdy);
endinterface

// File: rtl/tx_internal_rx.sv
// Receive end of the internal TX beat stream: framing check/repair, overflow drop, show-ahead FIFO.
// Statistics counters exist only when TX_INTERNAL_RX_STAT_EN is defined; otherwise they read 0.
module tx_internal_rx #(
  parameter int TX_DATA_W  = 32,
  parameter int PORT_ID_W  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_data_en,
  input  logic [TX_DATA_W-1:0] i_data,
  input  logic                 i_sop,
  input  logic                 i_eop,
  input  logic [PORT_ID_W-1:0] i_port_id,
  tx_internal_rx_if.master     o_stream,
  output logic [CNT_W-1:0]     o_pkt_cnt,
  output logic [CNT_W-1:0]     o_drop_cnt,
  output logic [CNT_W-1:0]     o_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LP_TWO   = (AW+1)'(2);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  typedef struct packed {
    logic [TX_DATA_W-1:0] data;
    logic [PORT_ID_W-1:0] port;
    logic                 sop;
    logic                 eop;
    logic                 err;
  } word_t;

  state_t      r_state, w_stateNext;
  logic        r_sVld, w_sVldNext;
  word_t       r_sWord, w_sWordNext;
  word_t       w_beat, w_wrWord, w_head;
  logic        w_wrEn, w_rdEn, w_vld;
  logic        w_incDrop, w_incErr;
  logic [AW:0] r_wrPtr, r_rdPtr, w_count, w_free;
  logic        w_hasRoom, w_hasTwo;
  word_t       r_mem [FIFO_DEPTH];

  assign w_beat    = '{data: i_data, port: i_port_id, sop: i_sop, eop: i_eop, err: 1'b0};
  assign w_count   = r_wrPtr - r_rdPtr;
  assign w_free    = LP_DEPTH - w_count;
  assign w_hasRoom = (w_free != '0);
  assign w_hasTwo  = (w_free >= LP_TWO);
  assign w_vld     = (r_wrPtr != r_rdPtr);
  assign w_rdEn    = w_vld & o_stream.rdy;

  // Free space is judged on registered occupancy only; a word leaving this
  // cycle is not counted, which keeps the write decision off the ready path.
  always_comb begin
    w_stateNext = r_state;
    w_sVldNext  = r_sVld;
    w_sWordNext = r_sWord;
    w_wrEn      = 1'b0;
    w_wrWord    = r_sWord;
    w_incDrop   = 1'b0;
    w_incErr    = 1'b0;
    if (r_sVld && r_sWord.eop) begin
      if (w_hasRoom) begin
        w_wrEn     = 1'b1;
        w_sVldNext = 1'b0;
      end
      if (i_data_en) begin
        if (i_sop) begin
          if (w_hasRoom) begin
            w_sVldNext  = 1'b1;
            w_sWordNext = w_beat;
            w_stateNext = i_eop ? IDLE : PKT;
          end else begin
            w_incDrop   = 1'b1;
            w_stateNext = i_eop ? IDLE : DROP;
          end
        end else if (r_state == IDLE) begin
          w_incErr = 1'b1;
        end else if (i_eop) begin
          w_stateNext = IDLE;
        end
      end
    end else if (r_sVld) begin
      // S holds a mid-packet word; any new beat forces it out.
      if (i_data_en) begin
        w_sVldNext  = 1'b0;
        w_stateNext = i_eop ? IDLE : DROP;
        if (i_sop) begin
          w_wrWord.eop = 1'b1;
          w_wrWord.err = 1'b1;
          if (w_hasRoom) begin
            w_wrEn      = 1'b1;
            w_incErr    = 1'b1;
            w_sVldNext  = 1'b1;
            w_sWordNext = w_beat;
            w_stateNext = i_eop ? IDLE : PKT;
          end else begin
            w_incDrop = 1'b1;
          end
        end else if (w_hasTwo) begin
          w_wrEn      = 1'b1;
          w_sVldNext  = 1'b1;
          w_sWordNext = w_beat;
          w_stateNext = i_eop ? IDLE : PKT;
        end else if (w_hasRoom) begin
          w_wrEn       = 1'b1;
          w_wrWord.eop = 1'b1;
          w_wrWord.err = 1'b1;
          w_incErr     = 1'b1;
        end else begin
          w_incDrop = 1'b1;
        end
      end
    end else if (i_data_en) begin
      if (i_sop) begin
        w_sVldNext  = 1'b1;
        w_sWordNext = w_beat;
        w_stateNext = i_eop ? IDLE : PKT;
      end else if (r_state == IDLE) begin
        w_incErr = 1'b1;
      end else if (i_eop) begin
        w_stateNext = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sVld  <= 1'b0;
      r_sWord <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      r_state <= w_stateNext;
      r_sVld  <= w_sVldNext;
      r_sWord <= w_sWordNext;
      if (w_wrEn) r_wrPtr <= r_wrPtr + LP_ONE;
      if (w_rdEn) r_rdPtr <= r_rdPtr + LP_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= w_wrWord;
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign w_head           = w_vld ? r_mem[r_rdPtr[AW-1:0]] : '0;
  assign o_stream.vld     = w_vld;
  assign o_stream.data    = w_head.data;
  assign o_stream.sop     = w_head.sop;
  assign o_stream.eop     = w_head.eop;
  assign o_stream.err     = w_head.err;
  assign o_stream.port_id = w_head.port;

`ifdef TX_INTERNAL_RX_STAT_EN
  logic [CNT_W-1:0] r_pktCnt, r_dropCnt, r_errCnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pktCnt  <= '0;
      r_dropCnt <= '0;
      r_errCnt  <= '0;
    end else begin
      if (w_wrEn && w_wrWord.eop) r_pktCnt <= r_pktCnt + CNT_W'(1);
      if (w_incDrop) r_dropCnt <= r_dropCnt + CNT_W'(1);
      if (w_incErr) r_errCnt <= r_errCnt + CNT_W'(1);
    end
  end

  assign o_pkt_cnt  = r_pktCnt;
  assign o_drop_cnt = r_dropCnt;
  assign o_err_cnt  = r_errCnt;
`else
  logic w_unusedStat;
  assign w_unusedStat = w_incDrop ^ w_incErr;
  assign o_pkt_cnt    = '0;
  assign o_drop_cnt   = '0;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_tx_internal_rx.sv
// Scoreboard bench for tx_internal_rx: directed packets push expected words, a monitor pops on each transfer.
// Counter expectations follow TX_INTERNAL_RX_STAT_EN (zero when the statistics are compiled out).
module tb_tx_internal_rx;
  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 32;
`ifdef TX_INTERNAL_RX_STAT_EN
  localparam logic STAT_ON = 1'b1;
`else
  localparam logic STAT_ON = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          err;
    logic [PW-1:0] port;
  } exp_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          dataEn = 1'b0;
  logic          sopIn  = 1'b0;
  logic          eopIn  = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic [PW-1:0] portIn = '0;
  logic [CW-1:0] pktCnt, dropCnt, errCnt;

  exp_t expQ[$];
  exp_t expHead;
  int   vectors     = 0;
  int   miscompares = 0;
  int   expPkt      = 0;
  int   expDrop     = 0;
  int   expErr      = 0;

  tx_internal_rx_if #(.TX_DATA_W(DW), .PORT_ID_W(PW)) outIf ();

  tx_internal_rx #(
    .TX_DATA_W(DW), .PORT_ID_W(PW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data_en(dataEn),
    .i_data(dataIn),
    .i_sop(sopIn),
    .i_eop(eopIn),
    .i_port_id(portIn),
    .o_stream(outIf),
    .o_pkt_cnt(pktCnt),
    .o_drop_cnt(dropCnt),
    .o_err_cnt(errCnt)
  );

  always #5 clk = ~clk;

  // Monitor: every word transferred at the coming edge must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && outIf.vld && outIf.rdy) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_word: got data=%0h sop=%0b eop=%0b err=%0b port=%0h, expected none",
                 outIf.data, outIf.sop, outIf.eop, outIf.err, outIf.port_id);
      end else begin
        expHead = expQ.pop_front();
        if (outIf.data !== expHead.data || outIf.sop !== expHead.sop || outIf.eop !== expHead.eop ||
            outIf.err !== expHead.err || outIf.port_id !== expHead.port) begin
          miscompares++;
          $display("[TB] FAIL word: got data=%0h sop=%0b eop=%0b err=%0b port=%0h, expected data=%0h sop=%0b eop=%0b err=%0b port=%0h",
                   outIf.data, outIf.sop, outIf.eop, outIf.err, outIf.port_id,
                   expHead.data, expHead.sop, expHead.eop, expHead.err, expHead.port);
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic e, input logic [DW-1:0] d, input logic [PW-1:0] p);
    dataEn = 1'b1;
    sopIn  = s;
    eopIn  = e;
    dataIn = d;
    portIn = p;
    @(posedge clk);
    #1;
    dataEn = 1'b0;
    sopIn  = 1'b0;
    eopIn  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectWord(input logic [DW-1:0] d, input logic s, input logic e, input logic er, input logic [PW-1:0] p);
    exp_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    w.err  = er;
    w.port = p;
    expQ.push_back(w);
  endtask

  task automatic checkOutput(input string name, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [CW-1:0] statExp(input int v);
    return STAT_ON ? CW'(v) : '0;
  endfunction

  task automatic checkStats(input string name);
    checkOutput({name, "_pkt_cnt"}, pktCnt, statExp(expPkt));
    checkOutput({name, "_drop_cnt"}, dropCnt, statExp(expDrop));
    checkOutput({name, "_err_cnt"}, errCnt, statExp(expErr));
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    idleCycles(2);
    checkOutput({name, "_drain_left"}, CW'(expQ.size()), '0);
  endtask

  initial begin
    outIf.rdy = 1'b1;
    idleCycles(3);
    rst_n = 1'b1;
    idleCycles(1);
    checkOutput("rst_vld", CW'(outIf.vld), '0);
    checkOutput("rst_data", CW'(outIf.data), '0);
    checkOutput("rst_sop", CW'(outIf.sop), '0);
    checkOutput("rst_eop", CW'(outIf.eop), '0);
    checkOutput("rst_err", CW'(outIf.err), '0);
    checkOutput("rst_port", CW'(outIf.port_id), '0);
    checkStats("rst");

    // Single-beat packet: visible two cycles after the beat.
    expectWord(8'hA5, 1'b1, 1'b1, 1'b0, 4'd3);
    applyStimulus(1'b1, 1'b1, 8'hA5, 4'd3);
    checkOutput("t1_vld_cycle1", CW'(outIf.vld), '0);
    idleCycles(1);
    checkOutput("t1_vld_cycle2", CW'(outIf.vld), CW'(1));
    waitDrain("t1");
    expPkt = 1;
    checkStats("t1");

    // Packet cut short by a new sop: third word repaired, second packet intact.
    expectWord(8'h10, 1'b1, 1'b0, 1'b0, 4'd1);
    expectWord(8'h11, 1'b0, 1'b0, 1'b0, 4'd1);
    expectWord(8'h12, 1'b0, 1'b1, 1'b1, 4'd1);
    expectWord(8'h20, 1'b1, 1'b0, 1'b0, 4'd2);
    expectWord(8'h21, 1'b0, 1'b0, 1'b0, 4'd2);
    expectWord(8'h22, 1'b0, 1'b0, 1'b0, 4'd2);
    expectWord(8'h23, 1'b0, 1'b1, 1'b0, 4'd2);
    applyStimulus(1'b1, 1'b0, 8'h10, 4'd1);
    applyStimulus(1'b0, 1'b0, 8'h11, 4'd1);
    applyStimulus(1'b0, 1'b0, 8'h12, 4'd1);
    applyStimulus(1'b1, 1'b0, 8'h20, 4'd2);
    applyStimulus(1'b0, 1'b0, 8'h21, 4'd2);
    applyStimulus(1'b0, 1'b0, 8'h22, 4'd2);
    applyStimulus(1'b0, 1'b1, 8'h23, 4'd2);
    waitDrain("t2");
    expPkt = 3;
    expErr = 1;
    checkStats("t2");

    // Stray non-sop beat in IDLE is discarded; a following packet is clean.
    applyStimulus(1'b0, 1'b0, 8'h33, 4'd5);
    idleCycles(3);
    expErr = 2;
    checkStats("t3_stray");
    expectWord(8'h40, 1'b1, 1'b0, 1'b0, 4'd6);
    expectWord(8'h41, 1'b0, 1'b1, 1'b0, 4'd6);
    applyStimulus(1'b1, 1'b0, 8'h40, 4'd6);
    applyStimulus(1'b0, 1'b1, 8'h41, 4'd6);
    waitDrain("t3");
    expPkt = 4;
    checkStats("t3");

    // Overflow: 10-beat packet into a 4-deep FIFO with no ready.
    outIf.rdy = 1'b0;
    expectWord(8'h50, 1'b1, 1'b0, 1'b0, 4'd7);
    expectWord(8'h51, 1'b0, 1'b0, 1'b0, 4'd7);
    expectWord(8'h52, 1'b0, 1'b0, 1'b0, 4'd7);
    expectWord(8'h53, 1'b0, 1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 10; i++)
      applyStimulus(i == 0, i == 9, 8'h50 + 8'(i), 4'd7);
    idleCycles(2);
    checkOutput("t4_head_vld", CW'(outIf.vld), CW'(1));
    checkOutput("t4_head_data", CW'(outIf.data), CW'(8'h50));
    checkOutput("t4_head_sop", CW'(outIf.sop), CW'(1));
    expPkt = 5;
    expErr = 3;
    checkStats("t4");

    // FIFO full: a 3-beat packet is dropped whole, a single-beat packet waits in S,
    // and a further packet arriving behind it is dropped.
    applyStimulus(1'b1, 1'b0, 8'h60, 4'd8);
    applyStimulus(1'b0, 1'b0, 8'h61, 4'd8);
    applyStimulus(1'b0, 1'b1, 8'h62, 4'd8);
    expectWord(8'h65, 1'b1, 1'b1, 1'b0, 4'd8);
    applyStimulus(1'b1, 1'b1, 8'h65, 4'd8);
    applyStimulus(1'b1, 1'b0, 8'h68, 4'd8);
    applyStimulus(1'b0, 1'b0, 8'h69, 4'd8);
    applyStimulus(1'b0, 1'b1, 8'h6A, 4'd8);
    idleCycles(2);
    checkOutput("t5_head_held", CW'(outIf.data), CW'(8'h50));
    expDrop = 2;
    checkStats("t5_full");
    outIf.rdy = 1'b1;
    waitDrain("t5_flush");
    expPkt = 6;
    checkStats("t5_flush");
    expectWord(8'h70, 1'b1, 1'b0, 1'b0, 4'd9);
    expectWord(8'h71, 1'b0, 1'b1, 1'b0, 4'd9);
    applyStimulus(1'b1, 1'b0, 8'h70, 4'd9);
    applyStimulus(1'b0, 1'b1, 8'h71, 4'd9);
    waitDrain("t5");
    expPkt = 7;
    checkStats("t5");

    // Reset mid-packet with three words buffered.
    outIf.rdy = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(i == 0, 1'b0, 8'h80 + 8'(i), 4'd4);
    idleCycles(1);
    checkOutput("t6_pre_vld", CW'(outIf.vld), CW'(1));
    checkOutput("t6_pre_data", CW'(outIf.data), CW'(8'h80));
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    expPkt  = 0;
    expDrop = 0;
    expErr  = 0;
    checkOutput("t6_rst_vld", CW'(outIf.vld), '0);
    checkOutput("t6_rst_data", CW'(outIf.data), '0);
    checkStats("t6_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(1);
    outIf.rdy = 1'b1;
    expectWord(8'h90, 1'b1, 1'b0, 1'b0, 4'd10);
    expectWord(8'h91, 1'b0, 1'b0, 1'b0, 4'd10);
    expectWord(8'h92, 1'b0, 1'b1, 1'b0, 4'd10);
    applyStimulus(1'b1, 1'b0, 8'h90, 4'd10);
    applyStimulus(1'b0, 1'b0, 8'h91, 4'd10);
    applyStimulus(1'b0, 1'b1, 8'h92, 4'd10);
    waitDrain("t6");
    expPkt = 1;
    checkStats("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
